pipe_skid_reg: RTL

- Parametrised successor to the fixed IF/ID latch: a generic inter-stage pipeline register carrying {instruction, pc} with a valid/ready handshake.
- Instantiated between any two pipeline stages (IF/ID, ID/EX, ...).
- Adds an optional second (skid) entry so in_ready is a registered signal and full throughput holds under back-pressure.
- Keeps the existing reset-to-boot-PC and flush-to-bubble semantics.

---
 rtl/pipe_skid_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic inter-stage pipeline register carrying {instruction, pc}.
// It uses a valid/ready handshake. With SKID=1 a second entry absorbs one beat
// of back-pressure, so in_ready is driven from state only.
// With SKID=0 there is a single entry, and in_ready passes out_ready through.
module pipe_skid_reg #(
  parameter int          INS_W    = 32,
  parameter int          PC_W     = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000,
  parameter bit          SKID     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic [1:0]       occupancy
);

  // Parameter constants keep only the LSBs that fit the target width.
  localparam logic [PC_W-1:0]  RST_PC_T = PC_W'(RESET_PC);
  localparam logic [INS_W-1:0] NOP_T    = INS_W'(NOP);

  // The state encoding is the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, nxt;

  logic             accept, consume;
  logic [INS_W-1:0] skid_ins;
  logic [PC_W-1:0]  skid_pc;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // State register: reset and flush both empty the block.
  always_ff @(posedge clk) begin
    if (reset)      state <= EMPTY;
    else if (flush) state <= EMPTY;
    else            state <= nxt;
  end

  // Next-state logic: the entry count moves by accept minus consume.
  always_comb begin
    nxt = state;
    case (state)
      EMPTY: if (accept) nxt = ONE;
      ONE: begin
        // The single-entry build cannot accept without consuming in ONE.
        if (accept && !consume)      nxt = SKID ? TWO : ONE;
        else if (!accept && consume) nxt = EMPTY;
      end
      TWO:     if (consume) nxt = ONE;
      default: nxt = EMPTY;
    endcase
  end

  // Outputs decoded from state; SKID=0 lets out_ready free the entry this cycle.
  always_comb begin
    occupancy = state;
    out_valid = (state != EMPTY);
    if (SKID) in_ready = (state != TWO);
    else      in_ready = (state == EMPTY) | out_ready;
  end

  // Datapath: the output register holds its last value when not reloaded.
  // The skid entry only fills when the output register is busy and stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_ins  <= NOP_T;
      out_pc   <= RST_PC_T;
      skid_ins <= '0;
      skid_pc  <= '0;
    end else if (flush) begin
      out_ins <= NOP_T;
      out_pc  <= '0;
    end else begin
      if (state == TWO && consume) begin
        out_ins <= skid_ins;
        out_pc  <= skid_pc;
      end else if (accept && (state == EMPTY || consume)) begin
        out_ins <= in_ins;
        out_pc  <= in_pc;
      end
      if (SKID && state == ONE && accept && !consume) begin
        skid_ins <= in_ins;
        skid_pc  <= in_pc;
      end
    end
  end

endmodule
